// File: rtl/pe_array_sched.sv
// pe_array_sched: loads every PE set's ifmap/filter scratchpads, broadcasts start, waits for all
// sets to complete and drains psums, repeating per ifmap pass. Optional watchdog: PE_SCHED_WATCHDOG_EN.
module pe_array_sched #(
    parameter int NUM_SETS   = 4,
    parameter int FILT_DEPTH = 224,
    parameter int IF_DEPTH   = 12
) (
    input  logic                clk,
    input  logic                reset,
    // Config handshake: a config transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready is high only in IDLE, and cfg_valid may be held or dropped freely while not ready.
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_S,
    input  logic [4:0]          cfg_P,
    input  logic [2:0]          cfg_Q,
    input  logic [7:0]          cfg_passes,
    output logic [NUM_SETS-1:0] set_sel,
    output logic                load,
    output logic                load2,
    output logic                load3,
    output logic                mem_rd_en,
    output logic [10:0]         mem_addr,
    output logic                start,
    input  logic [NUM_SETS-1:0] complete,
    output logic                psum_shift_en,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [3:0]          dbg_state
`ifdef PE_SCHED_WATCHDOG_EN
    ,
    output logic                timeout
`endif
);

    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD_IF = 4'd1,
        S_GAP1    = 4'd2,
        S_LOAD_F  = 4'd3,
        S_GAP2    = 4'd4,
        S_ARM     = 4'd5,
        S_START   = 4'd6,
        S_RUN     = 4'd7,
        S_DRAIN   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [10:0]         cnt_q, cnt_d;
    logic [7:0]          pass_q, pass_d;
    logic [7:0]          passes_q, passes_d;
    logic [3:0]          if_len_q, if_len_d;
    logic [10:0]         f_len_q, f_len_d;
    logic [4:0]          p_q, p_d;
    logic [NUM_SETS-1:0] capture_q, capture_d;
    logic                cfg_err_q, cfg_err_d;

    logic [NUM_SETS-1:0] set_sel_q, set_sel_d;
    logic                load_q, load_d, load2_q, load2_d, load3_q, load3_d;
    logic [10:0]         mem_addr_q, mem_addr_d;
    logic                start_q, start_d, psum_q, psum_d;
    logic                busy_q, busy_d, done_q, done_d, cfg_ready_q, cfg_ready_d;

`ifdef PE_SCHED_WATCHDOG_EN
    logic [15:0]         run_cnt_q, run_cnt_d;
    logic                timeout_q, timeout_d;
`endif

    // 12 bits holds any product of the raw input fields, so oversize configs compare correctly.
    logic [11:0] f_prod;
    logic        cfg_bad;

    always_comb begin
        f_prod  = 12'(cfg_S) * 12'(cfg_P) * 12'(cfg_Q);
        cfg_bad = (cfg_S == 4'd0) || (int'(cfg_S) > IF_DEPTH) || (cfg_P == 5'd0) ||
                  (cfg_Q == 3'd0) || (int'(f_prod) > FILT_DEPTH);
    end

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        passes_d  = passes_q;
        if_len_d  = if_len_q;
        f_len_d   = f_len_q;
        p_d       = p_q;
        capture_d = capture_q;
        cfg_err_d = cfg_err_q;
`ifdef PE_SCHED_WATCHDOG_EN
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        if_len_d  = cfg_S;
                        f_len_d   = f_prod[10:0];
                        p_d       = cfg_P;
                        passes_d  = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                        pass_d    = 8'd0;
                        set_d     = '0;
                        cnt_d     = 11'd0;
`ifdef PE_SCHED_WATCHDOG_EN
                        timeout_d = 1'b0;
`endif
                        state_d   = S_LOAD_IF;
                    end
                end
            end
            S_LOAD_IF: begin
                if (cnt_q == {7'd0, if_len_q} - 11'd1) begin
                    cnt_d   = 11'd0;
                    state_d = S_GAP1;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_GAP1: begin
                // Filters are only loaded on the first pass; later passes reuse them.
                if (pass_q == 8'd0) begin
                    state_d = S_LOAD_F;
                end else if (set_q == LAST_SET) begin
                    state_d = S_ARM;
                end else begin
                    set_d   = set_q + SET_W'(1);
                    state_d = S_LOAD_IF;
                end
            end
            S_LOAD_F: begin
                if (cnt_q == f_len_q - 11'd1) begin
                    cnt_d   = 11'd0;
                    state_d = S_GAP2;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_GAP2: begin
                if (set_q == LAST_SET) begin
                    state_d = S_ARM;
                end else begin
                    set_d   = set_q + SET_W'(1);
                    state_d = S_LOAD_IF;
                end
            end
            S_ARM: state_d = S_START;
            S_START: begin
                capture_d = complete;
`ifdef PE_SCHED_WATCHDOG_EN
                run_cnt_d = 16'd0;
`endif
                state_d   = S_RUN;
            end
            S_RUN: begin
                capture_d = capture_q | complete;
                if (&capture_d) begin
                    cnt_d   = 11'd0;
                    state_d = S_DRAIN;
`ifdef PE_SCHED_WATCHDOG_EN
                end else if (run_cnt_q == 16'hFFFE) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
`endif
                end
            end
            S_DRAIN: begin
                if (cnt_q == {6'd0, p_q} - 11'd1) begin
                    cnt_d = 11'd0;
                    if (({1'b0, pass_q} + 9'd1) < {1'b0, passes_q}) begin
                        pass_d  = pass_q + 8'd1;
                        set_d   = '0;
                        state_d = S_LOAD_IF;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the chip straight from flops.
        load2_d     = (state_d == S_LOAD_IF);
        load3_d     = (state_d == S_LOAD_F);
        load_d      = load2_d | load3_d;
        set_sel_d   = (state_d inside {S_LOAD_IF, S_GAP1, S_LOAD_F, S_GAP2}) ?
                      (NUM_SETS'(1) << set_d) : '0;
        mem_addr_d  = load_d ? cnt_d : 11'd0;
        start_d     = (state_d == S_START);
        psum_d      = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        cfg_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            set_q       <= '0;
            cnt_q       <= 11'd0;
            pass_q      <= 8'd0;
            passes_q    <= 8'd0;
            if_len_q    <= 4'd0;
            f_len_q     <= 11'd0;
            p_q         <= 5'd0;
            capture_q   <= '0;
            cfg_err_q   <= 1'b0;
            set_sel_q   <= '0;
            load_q      <= 1'b0;
            load2_q     <= 1'b0;
            load3_q     <= 1'b0;
            mem_addr_q  <= 11'd0;
            start_q     <= 1'b0;
            psum_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
`ifdef PE_SCHED_WATCHDOG_EN
            run_cnt_q   <= 16'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            passes_q    <= passes_d;
            if_len_q    <= if_len_d;
            f_len_q     <= f_len_d;
            p_q         <= p_d;
            capture_q   <= capture_d;
            cfg_err_q   <= cfg_err_d;
            set_sel_q   <= set_sel_d;
            load_q      <= load_d;
            load2_q     <= load2_d;
            load3_q     <= load3_d;
            mem_addr_q  <= mem_addr_d;
            start_q     <= start_d;
            psum_q      <= psum_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
`ifdef PE_SCHED_WATCHDOG_EN
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign set_sel       = set_sel_q;
    assign load          = load_q;
    assign load2         = load2_q;
    assign load3         = load3_q;
    assign mem_rd_en     = load_q;
    assign mem_addr      = mem_addr_q;
    assign start         = start_q;
    assign psum_shift_en = psum_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign dbg_state     = state_q;
`ifdef PE_SCHED_WATCHDOG_EN
    assign timeout       = timeout_q;
`endif

endmodule
